sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO; next generation of the team's 16x4 sync FIFO, generalised in data width and power-of-two depth. Adds a true fill count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. An optional first-word-fall-through (FWFT) read mode is selected by macro. Used as the generic buffer between producer/consumer stages in one clock domain.

---
 rtl/sync_fifo_pkg.sv | 23 ++
 rtl/sync_fifo_param_if.sv | 27 ++
 rtl/sync_fifo_dpram.sv | 26 ++
 rtl/sync_fifo_param.sv | 99 +++++++++
 tb/tb_sync_fifo_param.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers and defaults for the parametrised sync FIFO.
package sync_fifo_pkg;

    localparam int AE_THRESH_DEFAULT = 2;
    localparam int AF_MARGIN_DEFAULT = 2;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int count_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int af_default(input int addr_w);
        return (1 << addr_w) - AF_MARGIN_DEFAULT;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a producer/consumer and sync_fifo_param.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_dpram.sv
// Storage for sync_fifo_param: one write port, one registered read port.
module sync_fifo_dpram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the read register is cleared; the array keeps stale contents.
    always_ff @(posedge clk) begin
        if (rst_a)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = af_default(ADDR_W),
    parameter int AE_THRESH = AE_THRESH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_a,
    sync_fifo_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = count_w(ADDR_W);
    localparam int PTR_W = clog2_f(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_r;
    logic              ovf_r;
    logic              unf_r;
    logic              wr_acc;
    logic              rd_acc;
    logic              fetch;
    logic              empty_c;
    logic              full_c;
    logic [DATA_W-1:0] rdata;

    assign full_c = (count_r == DEPTH_C);
    assign wr_acc = bus.wr_en && !full_c;

`ifdef SYNC_FIFO_FWFT_EN
    // The RAM read register doubles as the prefetch stage; out_vld marks it live.
    logic out_vld;

    assign empty_c = !out_vld;
    assign rd_acc  = bus.rd_en && out_vld;
    assign fetch   = (count_r > CNT_W'(out_vld)) && (!out_vld || rd_acc);

    always_ff @(posedge clk) begin
        if (rst_a)       out_vld <= 1'b0;
        else if (fetch)  out_vld <= 1'b1;
        else if (rd_acc) out_vld <= 1'b0;
    end
`else
    assign empty_c = (count_r == '0);
    assign rd_acc  = bus.rd_en && !empty_c;
    assign fetch   = rd_acc;
`endif

    always_ff @(posedge clk) begin
        if (rst_a) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fetch)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            ovf_r <= bus.wr_en && full_c;
            unf_r <= bus.rd_en && empty_c;
        end
    end

    sync_fifo_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_a (rst_a),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .re    (fetch),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.data_out     = rdata;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_r >= AF_C);
    assign bus.almost_empty = (count_r <= AE_C);
    assign bus.count        = count_r;
    assign bus.overflow     = ovf_r;
    assign bus.underflow    = unf_r;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH 8, AF 6, AE 2) against a queue model.
module tb_sync_fifo_param;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst_a;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sync_fifo_param #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk   (clk),
        .rst_a (rst_a),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_ovf;
    logic          exp_unf;

    function automatic logic [9:0] dut_status();
        return {bus.empty, bus.full, bus.almost_full, bus.almost_empty,
                bus.count, bus.overflow, bus.underflow};
    endfunction

    function automatic logic [9:0] model_status();
        int n;
        n = q.size();
        return {n == 0, n == DEPTH, n >= AF, n <= AE, 4'(n), exp_ovf, exp_unf};
    endfunction

    // Drive one cycle of requests and advance the model by the FIFO's rules.
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd);
        int  n;
        bit  wr_ok;
        bit  rd_ok;
        bus.wr_en   = wr;
        bus.data_in = d;
        bus.rd_en   = rd;
        n     = q.size();
        rd_ok = rd && (n > 0);
        wr_ok = wr && (n < DEPTH);
        @(posedge clk);
        if (rd_ok) exp_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        exp_ovf = wr && !wr_ok;
        exp_unf = rd && !rd_ok;
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset(input bit wr_during);
        rst_a       = 1'b1;
        bus.wr_en   = wr_during;
        bus.data_in = 8'h77;
        bus.rd_en   = 1'b0;
        @(posedge clk);
        #1;
        rst_a     = 1'b0;
        bus.wr_en = 1'b0;
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        @(posedge clk);
        #1;
        total++;
        if (dut_status() !== 10'b1001_0000_00)
            $display("FAIL reset_status got=%b exp=%b", dut_status(), 10'b1001_0000_00);
        else passed++;
        total++;
        if (bus.data_out !== 8'h00)
            $display("FAIL reset_dout got=%h exp=00", bus.data_out);
        else passed++;
    endtask

    task automatic test_fill();
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h11 + i), 1'b0);
            total++;
            if (dut_status() !== model_status())
                $display("FAIL fill_status[%0d] got=%b exp=%b", i, dut_status(), model_status());
            else passed++;
        end
        step(1'b1, 8'h99, 1'b0);
        total++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b1 || bus.count !== 4'd8)
            $display("FAIL fill_overflow full=%b ovf=%b count=%0d exp 1 1 8",
                     bus.full, bus.overflow, bus.count);
        else passed++;
        step(1'b0, 8'h00, 1'b0);
        total++;
        if (dut_status() !== model_status())
            $display("FAIL fill_ovf_clear got=%b exp=%b", dut_status(), model_status());
        else passed++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1);
            total++;
            if (bus.data_out !== 8'(8'h11 + i) || dut_status() !== model_status())
                $display("FAIL drain[%0d] dout=%h exp=%h status=%b exp=%b", i,
                         bus.data_out, 8'(8'h11 + i), dut_status(), model_status());
            else passed++;
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if (bus.underflow !== 1'b1 || bus.empty !== 1'b1 || bus.data_out !== 8'h18)
            $display("FAIL drain_underflow unf=%b empty=%b dout=%h exp 1 1 18",
                     bus.underflow, bus.empty, bus.data_out);
        else passed++;
    endtask

    task automatic test_full_rdwr();
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        total++;
        if (bus.count !== 4'd7 || bus.overflow !== 1'b1 || bus.data_out !== exp_dout)
            $display("FAIL full_rdwr count=%0d ovf=%b dout=%h exp 7 1 %h",
                     bus.count, bus.overflow, bus.data_out, exp_dout);
        else passed++;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'($urandom), 1'b1);
        total++;
        if (bus.count !== 4'd4 || bus.data_out !== exp_dout)
            $display("FAIL mid_rdwr count=%0d dout=%h exp 4 %h", bus.count, bus.data_out, exp_dout);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom));
            total++;
            if (bus.data_out !== exp_dout || dut_status() !== model_status())
                $display("FAIL wrap_mix[%0d] dout=%h exp=%h status=%b exp=%b", i,
                         bus.data_out, exp_dout, dut_status(), model_status());
            else passed++;
        end
    endtask

    task automatic test_random();
        do_reset(1'b0);
        for (int i = 0; i < 300; i++) begin
            int wr_pct;
            wr_pct = ((i / 50) % 2 == 0) ? 75 : 25;
            step($urandom_range(99) < wr_pct, 8'($urandom), $urandom_range(99) < 50);
            total++;
            if (bus.data_out !== exp_dout || dut_status() !== model_status())
                $display("FAIL random[%0d] dout=%h exp=%h status=%b exp=%b", i,
                         bus.data_out, exp_dout, dut_status(), model_status());
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        do_reset(1'b1);
        total++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.data_out !== 8'h00)
            $display("FAIL reset_mid count=%0d empty=%b dout=%h exp 0 1 00",
                     bus.count, bus.empty, bus.data_out);
        else passed++;
        step(1'b0, 8'h00, 1'b1);
        total++;
        if (bus.underflow !== 1'b1 || dut_status() !== model_status())
            $display("FAIL reset_mid_unf got=%b exp=%b", dut_status(), model_status());
        else passed++;
    endtask

    task automatic test_fwft();
        logic [DW-1:0] words [3];
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;
        do_reset(1'b0);
        bus.wr_en = 1'b1; bus.data_in = 8'h5A;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        total++;
        if (bus.empty !== 1'b1 || bus.count !== 4'd1)
            $display("FAIL fwft_lat1 empty=%b count=%0d exp 1 1", bus.empty, bus.count);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (bus.empty !== 1'b0 || bus.data_out !== 8'h5A)
            $display("FAIL fwft_lat2 empty=%b dout=%h exp 0 5a", bus.empty, bus.data_out);
        else passed++;
        bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        total++;
        if (bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.data_out !== 8'h5A)
            $display("FAIL fwft_pop empty=%b count=%0d dout=%h exp 1 0 5a",
                     bus.empty, bus.count, bus.data_out);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.data_in = words[i];
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.empty !== 1'b0 || bus.data_out !== words[i] || bus.count !== 4'(3 - i))
                $display("FAIL fwft_head[%0d] empty=%b dout=%h count=%0d exp 0 %h %0d", i,
                         bus.empty, bus.data_out, bus.count, words[i], 3 - i);
            else passed++;
            bus.rd_en = 1'b1;
            @(posedge clk); #1;
            bus.rd_en = 1'b0;
        end
        total++;
        if (bus.empty !== 1'b1 || bus.count !== 4'd0)
            $display("FAIL fwft_drained empty=%b count=%0d exp 1 0", bus.empty, bus.count);
        else passed++;
    endtask

    initial begin
        rst_a       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        exp_dout    = '0;
        exp_ovf     = 1'b0;
        exp_unf     = 1'b0;
        test_reset();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`else
        test_fill();
        test_drain();
        test_full_rdwr();
        test_reset_mid();
        test_random();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
